// File: rtl/svc_axi_router_rd_if.sv
// rtl/svc_axi_router_rd_if.sv - AXI read-channel bundle between one manager and NUM_S subordinate lanes
interface svc_axi_router_rd_if #(
    parameter int NUM_S          = 2,
    parameter int AXI_ADDR_WIDTH = 8,
    parameter int AXI_DATA_WIDTH = 16,
    parameter int AXI_ID_WIDTH   = 4
);
    logic                                        s_axi_arvalid;
    logic                                        s_axi_arready;
    logic [AXI_ID_WIDTH-1:0]                     s_axi_arid;
    logic [AXI_ADDR_WIDTH-1:0]                   s_axi_araddr;
    logic [7:0]                                  s_axi_arlen;
    logic [2:0]                                  s_axi_arsize;
    logic [1:0]                                  s_axi_arburst;
    logic                                        s_axi_rvalid;
    logic                                        s_axi_rready;
    logic [AXI_ID_WIDTH-1:0]                     s_axi_rid;
    logic [AXI_DATA_WIDTH-1:0]                   s_axi_rdata;
    logic [1:0]                                  s_axi_rresp;
    logic                                        s_axi_rlast;

    logic [NUM_S-1:0]                            m_axi_arvalid;
    logic [NUM_S-1:0]                            m_axi_arready;
    logic [NUM_S-1:0][AXI_ID_WIDTH-1:0]          m_axi_arid;
    logic [NUM_S-1:0][AXI_ADDR_WIDTH-1:0]        m_axi_araddr;
    logic [NUM_S-1:0][7:0]                       m_axi_arlen;
    logic [NUM_S-1:0][2:0]                       m_axi_arsize;
    logic [NUM_S-1:0][1:0]                       m_axi_arburst;
    logic [NUM_S-1:0]                            m_axi_rvalid;
    logic [NUM_S-1:0]                            m_axi_rready;
    logic [NUM_S-1:0][AXI_ID_WIDTH-1:0]          m_axi_rid;
    logic [NUM_S-1:0][AXI_DATA_WIDTH-1:0]        m_axi_rdata;
    logic [NUM_S-1:0][1:0]                       m_axi_rresp;
    logic [NUM_S-1:0]                            m_axi_rlast;

    // Router side: accepts upstream AR, drives downstream AR lanes.
    modport slave (
        input  s_axi_arvalid, s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst,
        input  s_axi_rready,
        output s_axi_arready, s_axi_rvalid, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast,
        output m_axi_arvalid, m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
        output m_axi_rready,
        input  m_axi_arready, m_axi_rvalid, m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast
    );

    // Environment side: upstream manager plus the subordinate models.
    modport master (
        output s_axi_arvalid, s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst,
        output s_axi_rready,
        input  s_axi_arready, s_axi_rvalid, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast,
        input  m_axi_arvalid, m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
        input  m_axi_rready,
        output m_axi_arready, m_axi_rvalid, m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast
    );
endinterface

// File: rtl/svc_axi_router_rd.sv
// rtl/svc_axi_router_rd.sv - 1-to-NUM_S AXI read router, one burst in flight, DECERR for unmapped selects
module svc_axi_router_rd #(
    parameter int NUM_S          = 2,
    parameter int AXI_ADDR_WIDTH = 8,
    parameter int AXI_DATA_WIDTH = 16,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int SEL_WIDTH      = $clog2(NUM_S)
) (
    input  logic clk,
    input  logic rst_n,
    svc_axi_router_rd_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA, ERR} state_t;

    state_t                    state_q, state_d;
    logic                      arready_q;
    logic [NUM_S-1:0]          arvalid_q, arvalid_d;
    logic [SEL_WIDTH-1:0]      sel_q, sel_d, dec_sel;
    logic [7:0]                cnt_q, cnt_d;
    logic [AXI_ID_WIDTH-1:0]   id_q;
    logic [AXI_ADDR_WIDTH-1:0] addr_q;
    logic [7:0]                len_q;
    logic [2:0]                size_q;
    logic [1:0]                burst_q;
    logic                      ar_hs, dec_ok;

    logic                      r_valid, r_last;
    logic [AXI_ID_WIDTH-1:0]   r_id;
    logic [AXI_DATA_WIDTH-1:0] r_data;
    logic [1:0]                r_resp;
    logic [NUM_S-1:0]          r_ready_lanes;

    assign dec_sel = bus.s_axi_araddr[AXI_ADDR_WIDTH-1 -: SEL_WIDTH];
    assign dec_ok  = {1'b0, dec_sel} < (SEL_WIDTH+1)'(NUM_S);
    assign ar_hs   = bus.s_axi_arvalid && arready_q;

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        cnt_d         = cnt_q;
        arvalid_d     = '0;
        r_valid       = 1'b0;
        r_last        = 1'b0;
        r_id          = '0;
        r_data        = '0;
        r_resp        = 2'b00;
        r_ready_lanes = '0;
        case (state_q)
            IDLE: begin
                if (ar_hs) begin
                    sel_d = dec_sel;
                    if (dec_ok) begin
                        state_d = ADDR;
                    end else begin
                        state_d = ERR;
                        cnt_d   = bus.s_axi_arlen;
                    end
                end
            end
            ADDR: begin
                // arvalid_q is one-hot on sel, so this is the selected lane's handshake.
                if (|(arvalid_q & bus.m_axi_arready)) state_d = DATA;
            end
            DATA: begin
                for (int i = 0; i < NUM_S; i++) begin
                    if (sel_q == SEL_WIDTH'(i)) begin
                        r_valid          = bus.m_axi_rvalid[i];
                        r_id             = bus.m_axi_rid[i];
                        r_data           = bus.m_axi_rdata[i];
                        r_resp           = bus.m_axi_rresp[i];
                        r_last           = bus.m_axi_rlast[i];
                        r_ready_lanes[i] = bus.s_axi_rready;
                    end
                end
                if (r_valid && bus.s_axi_rready && r_last) state_d = IDLE;
            end
            ERR: begin
                r_valid = 1'b1;
                r_id    = id_q;
                r_resp  = 2'b11;
                r_last  = (cnt_q == 8'd0);
                if (bus.s_axi_rready) begin
                    if (cnt_q == 8'd0) state_d = IDLE;
                    else               cnt_d   = cnt_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d == ADDR) begin
            for (int i = 0; i < NUM_S; i++) begin
                if (sel_d == SEL_WIDTH'(i)) arvalid_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            arready_q <= 1'b0;
            arvalid_q <= '0;
            sel_q     <= '0;
            cnt_q     <= '0;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
        end else begin
            state_q   <= state_d;
            arready_q <= (state_d == IDLE);
            arvalid_q <= arvalid_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            if (ar_hs) begin
                id_q    <= bus.s_axi_arid;
                addr_q  <= bus.s_axi_araddr;
                len_q   <= bus.s_axi_arlen;
                size_q  <= bus.s_axi_arsize;
                burst_q <= bus.s_axi_arburst;
            end
        end
    end

    assign bus.s_axi_arready = arready_q;
    assign bus.m_axi_arvalid = arvalid_q;
    assign bus.m_axi_rready  = r_ready_lanes;
    assign bus.s_axi_rvalid  = r_valid;
    assign bus.s_axi_rid     = r_id;
    assign bus.s_axi_rdata   = r_data;
    assign bus.s_axi_rresp   = r_resp;
    assign bus.s_axi_rlast   = r_last;

    // Payload is broadcast; only the lane with arvalid acts on it.
    always_comb begin
        for (int i = 0; i < NUM_S; i++) begin
            bus.m_axi_arid[i]    = id_q;
            bus.m_axi_araddr[i]  = addr_q;
            bus.m_axi_arlen[i]   = len_q;
            bus.m_axi_arsize[i]  = size_q;
            bus.m_axi_arburst[i] = burst_q;
        end
    end
endmodule
